lilmaster: RTL and testbench

Unibus single-cycle master driven by the ARM register interface: the ARM loads address, function and write data, then starts one DATI, DATO or DATOB transfer. The block optionally arbitrates for the bus via NPR/NPG/SACK, drives the address, control and data lines, and asserts MSYN after deskew. It waits for a responder such as the 4KB memory block to return SSYN, captures read data and releases the bus. It is the initiator end of the responder protocol, for ARM-side memory/device probing and loading.

---
 rtl/lilmaster_pkg.sv | 32 +++
 rtl/lilmaster_arb.sv | 39 +++
 rtl/lilmaster.sv | 240 ++++++++++++++++++++++++
 tb/tb_lilmaster.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lilmaster_pkg.sv
// Shared types and constants for the lilmaster Unibus master.
package lilmaster_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_SACK,
    S_SEIZE,
    S_DESKEW,
    S_MSYN,
    S_UNSYN,
    S_RELEASE
  } state_t;

  localparam logic [1:0] REG_ID   = 2'd0;
  localparam logic [1:0] REG_CSR  = 2'd1;
  localparam logic [1:0] REG_DATA = 2'd2;
  localparam logic [1:0] REG_CNT  = 2'd3;

  localparam logic [31:0] ID_WORD  = 32'h424D1001;
  localparam logic [15:0] DATA_RST = 16'hBAAD;

  localparam logic [1:0] FN_DATI  = 2'b00;
  localparam logic [1:0] FN_DATO  = 2'b10;
  localparam logic [1:0] FN_DATOB = 2'b11;

  // Code 01 has no bus meaning here; it is issued as a plain DATI.
  function automatic logic [1:0] bus_func(input logic [1:0] f);
    return f[1] ? f : FN_DATI;
  endfunction

endpackage

// File: rtl/lilmaster_arb.sv
// NPR/NPG/SACK handshake for lilmaster; instantiated only when LILMASTER_NPR_EN is defined.
module lilmaster_arb (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic req,
  input  logic seize,
  input  logic npg,
  input  logic bbsy,
  input  logic ssyn,
  output logic npr,
  output logic sack,
  output logic granted,
  output logic won
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      npr  <= 1'b0;
      sack <= 1'b0;
    end else if (clr) begin
      npr  <= 1'b0;
      sack <= 1'b0;
    end else begin
      if (req) begin
        npr <= 1'b1;
      end else if (granted) begin
        npr  <= 1'b0;
        sack <= 1'b1;
      end
      if (seize) sack <= 1'b0;
    end
  end

  assign granted = npr & npg;
  // Bus is ours once the grant is withdrawn and the previous master has left.
  assign won     = sack & ~npg & ~bbsy & ~ssyn;

endmodule

// File: rtl/lilmaster.sv
// Unibus single-cycle master (DATI/DATO/DATOB) under ARM register control.
// Define LILMASTER_NPR_EN to compile in NPR/SACK arbitration before bus seizure.
module lilmaster
  import lilmaster_pkg::*;
#(
  parameter int unsigned DESKEW  = 8,
  parameter int unsigned TIMEOUT = 1000
) (
  input  logic        CLOCK,
  input  logic        RESET_N,
  input  logic        armwrite,
  input  logic [1:0]  armraddr,
  input  logic [1:0]  armwaddr,
  input  logic [31:0] armwdata,
  output logic [31:0] armrdata,
  input  logic [15:0] d_in_h,
  input  logic        ssyn_in_h,
  input  logic        bbsy_in_h,
  input  logic        init_in_h,
  input  logic        npg_in_h,
  output logic [17:0] a_out_h,
  output logic [1:0]  c_out_h,
  output logic [15:0] d_out_h,
  output logic        msyn_out_h,
  output logic        bbsy_out_h,
  output logic        npr_out_h,
  output logic        sack_out_h
);

  localparam logic [15:0] DESKEW_LD    = 16'(DESKEW - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

  state_t      state_q, state_n;
  logic [17:0] addr_q, addr_n;
  logic [1:0]  func_q, func_n;
  logic [15:0] data_q, data_n;
  logic [15:0] cyccnt_q, cyccnt_n;
  logic        timo_q, timo_n;
  logic [17:0] a_q, a_n;
  logic [1:0]  c_q, c_n;
  logic [15:0] d_q, d_n;
  logic        msyn_q, msyn_n;
  logic        bbsy_q, bbsy_n;
  logic [15:0] dcnt_q, dcnt_n;
  logic [15:0] tcnt_q, tcnt_n;

  logic busy, wr_csr, wr_data, go, abort_hit, seize;

  assign busy      = (state_q != S_IDLE);
  assign wr_csr    = armwrite && (armwaddr == REG_CSR);
  assign wr_data   = armwrite && (armwaddr == REG_DATA);
  assign go        = wr_csr && armwdata[31] && !busy && !init_in_h;
  assign abort_hit = armwrite && (armwaddr == REG_CNT) && armwdata[31] && busy;

`ifdef LILMASTER_NPR_EN
  logic arb_granted, arb_won;

  lilmaster_arb u_arb (
    .clk     (CLOCK),
    .rst_n   (RESET_N),
    .clr     (init_in_h | abort_hit),
    .req     (go),
    .seize   (seize),
    .npg     (npg_in_h),
    .bbsy    (bbsy_in_h),
    .ssyn    (ssyn_in_h),
    .npr     (npr_out_h),
    .sack    (sack_out_h),
    .granted (arb_granted),
    .won     (arb_won)
  );

  logic unused_bits;
  assign unused_bits = ^armwdata[30:20];
`else
  assign npr_out_h  = 1'b0;
  assign sack_out_h = 1'b0;

  logic unused_bits;
  assign unused_bits = ^{npg_in_h, seize, armwdata[30:20]};
`endif

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      func_q   <= FN_DATI;
      data_q   <= DATA_RST;
      cyccnt_q <= '0;
      timo_q   <= 1'b0;
      a_q      <= '0;
      c_q      <= '0;
      d_q      <= '0;
      msyn_q   <= 1'b0;
      bbsy_q   <= 1'b0;
      dcnt_q   <= '0;
      tcnt_q   <= '0;
    end else begin
      state_q  <= state_n;
      addr_q   <= addr_n;
      func_q   <= func_n;
      data_q   <= data_n;
      cyccnt_q <= cyccnt_n;
      timo_q   <= timo_n;
      a_q      <= a_n;
      c_q      <= c_n;
      d_q      <= d_n;
      msyn_q   <= msyn_n;
      bbsy_q   <= bbsy_n;
      dcnt_q   <= dcnt_n;
      tcnt_q   <= tcnt_n;
    end
  end

  always_comb begin
    state_n  = state_q;
    addr_n   = addr_q;
    func_n   = func_q;
    data_n   = data_q;
    cyccnt_n = cyccnt_q;
    timo_n   = timo_q;
    a_n      = a_q;
    c_n      = c_q;
    d_n      = d_q;
    msyn_n   = msyn_q;
    bbsy_n   = bbsy_q;
    dcnt_n   = dcnt_q;
    tcnt_n   = tcnt_q;
    seize    = 1'b0;

    if (wr_csr && !busy) begin
      addr_n = armwdata[17:0];
      func_n = armwdata[19:18];
    end
    if (wr_data && !busy) data_n = armwdata[15:0];

    // Priority: INIT, then ARM abort, then per-state timeout, then SSYN.
    if (init_in_h) begin
      state_n = S_IDLE;
      a_n     = '0;
      c_n     = '0;
      d_n     = '0;
      msyn_n  = 1'b0;
      bbsy_n  = 1'b0;
      if (busy) timo_n = 1'b1;
    end else if (abort_hit) begin
      state_n = S_RELEASE;
      msyn_n  = 1'b0;
      timo_n  = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (go) begin
            timo_n = 1'b0;
`ifdef LILMASTER_NPR_EN
            state_n = S_REQ;
`else
            state_n = S_SEIZE;
`endif
          end
        end
`ifdef LILMASTER_NPR_EN
        S_REQ:  if (arb_granted) state_n = S_SACK;
        S_SACK: if (arb_won) state_n = S_SEIZE;
`endif
        S_SEIZE: begin
          if (!bbsy_in_h && !ssyn_in_h) begin
            seize   = 1'b1;
            bbsy_n  = 1'b1;
            a_n     = addr_q;
            c_n     = bus_func(func_q);
            if (func_q[1]) d_n = data_q;
            dcnt_n  = DESKEW_LD;
            state_n = S_DESKEW;
          end
        end
        S_DESKEW: begin
          if (dcnt_q == '0) begin
            msyn_n  = 1'b1;
            tcnt_n  = '0;
            state_n = S_MSYN;
          end else begin
            dcnt_n = dcnt_q - 16'd1;
          end
        end
        S_MSYN: begin
          if (tcnt_q == TIMEOUT_LAST) begin
            timo_n  = 1'b1;
            msyn_n  = 1'b0;
            state_n = S_RELEASE;
          end else if (ssyn_in_h) begin
            if (!func_q[1]) data_n = d_in_h;
            msyn_n  = 1'b0;
            tcnt_n  = '0;
            state_n = S_UNSYN;
          end else begin
            tcnt_n = tcnt_q + 16'd1;
          end
        end
        S_UNSYN: begin
          if (tcnt_q == TIMEOUT_LAST) begin
            timo_n  = 1'b1;
            state_n = S_RELEASE;
          end else if (!ssyn_in_h) begin
            state_n = S_RELEASE;
          end else begin
            tcnt_n = tcnt_q + 16'd1;
          end
        end
        S_RELEASE: begin
          a_n     = '0;
          c_n     = '0;
          d_n     = '0;
          msyn_n  = 1'b0;
          bbsy_n  = 1'b0;
          if (!timo_q) cyccnt_n = cyccnt_q + 16'd1;
          state_n = S_IDLE;
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_comb begin
    armrdata = '0;
    case (armraddr)
      REG_ID:   armrdata = ID_WORD;
      REG_CSR:  armrdata = {busy, timo_q, 10'b0, func_q, addr_q};
      REG_DATA: armrdata = {16'b0, data_q};
      default:  armrdata = {16'b0, cyccnt_q};
    endcase
  end

  assign a_out_h    = a_q;
  assign c_out_h    = c_q;
  assign d_out_h    = d_q;
  assign msyn_out_h = msyn_q;
  assign bbsy_out_h = bbsy_q;

endmodule

// File: tb/tb_lilmaster.sv
// Self-checking bench for lilmaster: directed protocol cases plus random transfers
// against a memory responder and a register-level reference model.
module tb_lilmaster;

  localparam int unsigned DSK = 5;
  localparam int unsigned TMO = 60;

  logic        CLOCK;
  logic        RESET_N;
  logic        armwrite;
  logic [1:0]  armraddr, armwaddr;
  logic [31:0] armwdata, armrdata;
  logic [15:0] d_in_h;
  logic        ssyn_in_h, bbsy_in_h, init_in_h, npg_in_h;
  logic [17:0] a_out_h;
  logic [1:0]  c_out_h;
  logic [15:0] d_out_h;
  logic        msyn_out_h, bbsy_out_h, npr_out_h, sack_out_h;

  lilmaster #(.DESKEW(DSK), .TIMEOUT(TMO)) dut (
    .CLOCK(CLOCK), .RESET_N(RESET_N), .armwrite(armwrite),
    .armraddr(armraddr), .armwaddr(armwaddr), .armwdata(armwdata), .armrdata(armrdata),
    .d_in_h(d_in_h), .ssyn_in_h(ssyn_in_h), .bbsy_in_h(bbsy_in_h), .init_in_h(init_in_h),
    .npg_in_h(npg_in_h), .a_out_h(a_out_h), .c_out_h(c_out_h), .d_out_h(d_out_h),
    .msyn_out_h(msyn_out_h), .bbsy_out_h(bbsy_out_h), .npr_out_h(npr_out_h),
    .sack_out_h(sack_out_h)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  int n_chk;
  int n_err;

  // Responder memory (bus side) and reference memory (expected contents).
  logic [15:0] mem     [0:4095];
  logic [15:0] ref_mem [0:4095];
  logic        resp_en;
  int          resp_lat;
  int          resp_wait;
  int          gnt_dly;
  int          gnt_cnt;

  logic [15:0] m_data;
  logic [15:0] m_cnt;

  function automatic logic [15:0] seed_word(input int i);
    return (i == 12'h100) ? 16'o123456 : 16'((i * 40503) ^ 16'h5A5A);
  endfunction

  // Memory responder: samples MSYN away from the clock edge, answers after resp_lat cycles.
  always @(negedge CLOCK) begin
    if (!RESET_N) begin
      for (int i = 0; i < 4096; i++) mem[i] = seed_word(i);
      ssyn_in_h = 1'b0;
      d_in_h    = 16'h0;
      resp_wait = 0;
    end else if (!msyn_out_h) begin
      ssyn_in_h = 1'b0;
      resp_wait = 0;
    end else if (resp_en && !ssyn_in_h) begin
      if (resp_wait >= resp_lat) begin
        case (c_out_h)
          2'b10: mem[a_out_h[12:1]] = d_out_h;
          2'b11: begin
            if (a_out_h[0]) mem[a_out_h[12:1]][15:8] = d_out_h[15:8];
            else            mem[a_out_h[12:1]][7:0]  = d_out_h[7:0];
          end
          default: d_in_h = mem[a_out_h[12:1]];
        endcase
        ssyn_in_h = 1'b1;
      end else begin
        resp_wait++;
      end
    end
  end

  // NPR arbiter model: grants after gnt_dly cycles of request, withdraws on SACK.
  always @(negedge CLOCK) begin
    if (!RESET_N) begin
      npg_in_h = 1'b0;
      gnt_cnt  = 0;
    end else if (sack_out_h) begin
      npg_in_h = 1'b0;
      gnt_cnt  = 0;
    end else if (npr_out_h && !npg_in_h) begin
      if (gnt_cnt >= gnt_dly) npg_in_h = 1'b1;
      else gnt_cnt++;
    end else if (!npr_out_h) begin
      gnt_cnt = 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] idx, input logic [31:0] val);
    @(negedge CLOCK);
    armwaddr = idx;
    armwdata = val;
    armwrite = 1'b1;
    @(negedge CLOCK);
    armwrite = 1'b0;
  endtask

  task automatic rd(input logic [1:0] idx, output logic [31:0] val);
    armraddr = idx;
    #1;
    val = armrdata;
  endtask

  task automatic start_cycle(input logic [1:0] f, input logic [17:0] a);
    wr(2'd1, {1'b1, 11'd0, f, a});
  endtask

  task automatic wait_idle(input int maxc);
    logic [31:0] v;
    logic        done;
    done = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      rd(2'd1, v);
      if (!v[31]) begin
        done = 1'b1;
        break;
      end
      @(negedge CLOCK);
    end
    chk("idle_reached", {31'd0, done}, 32'd1);
  endtask

  task automatic wait_msyn(input int maxc);
    for (int i = 0; i < maxc; i++) begin
      if (msyn_out_h) break;
      @(negedge CLOCK);
    end
    chk("msyn_seen", {31'd0, msyn_out_h}, 32'd1);
  endtask

  // Completes a successful transfer and applies its effect to the reference model.
  task automatic finish_cycle(input logic [1:0] f, input logic [17:0] a);
    logic [31:0] v;
    logic [11:0] w;
    wait_idle(3 * TMO + DSK + 40);
    w = a[12:1];
    if (!f[1])              m_data = ref_mem[w];
    else if (f == 2'b10)    ref_mem[w] = m_data;
    else if (a[0])          ref_mem[w][15:8] = m_data[15:8];
    else                    ref_mem[w][7:0]  = m_data[7:0];
    m_cnt++;
    rd(2'd1, v); chk("csr", v, {2'b00, 10'd0, f, a});
    rd(2'd2, v); chk("data", v, {16'd0, m_data});
    rd(2'd3, v); chk("cyccnt", v, {16'd0, m_cnt});
    chk("mem", {16'd0, mem[w]}, {16'd0, ref_mem[w]});
  endtask

  task automatic bus_idle_chk(input string tag);
    chk(tag, {a_out_h, c_out_h, d_out_h, msyn_out_h, bbsy_out_h},
        {18'd0, 2'd0, 16'd0, 1'b0, 1'b0});
  endtask

  initial begin
    logic [31:0] v;
    logic [1:0]  f;
    logic [17:0] a;
    logic [15:0] d;
    int          k;
    int          hi;
    logic        bad;
    logic        seen;

    n_chk = 0; n_err = 0;
    RESET_N = 1'b0; armwrite = 1'b0; armraddr = 2'd0; armwaddr = 2'd0; armwdata = '0;
    bbsy_in_h = 1'b0; init_in_h = 1'b0;
    resp_en = 1'b1; resp_lat = 0; gnt_dly = 2;
    for (int i = 0; i < 4096; i++) ref_mem[i] = seed_word(i);
    m_data = 16'hBAAD;
    m_cnt  = 16'd0;

    // Reset values
    repeat (3) @(negedge CLOCK);
    bus_idle_chk("reset_bus");
    chk("reset_arb", {30'd0, npr_out_h, sack_out_h}, 32'd0);
    RESET_N = 1'b1;
    @(negedge CLOCK);
    rd(2'd0, v); chk("id", v, 32'h424D1001);
    rd(2'd1, v); chk("reset_csr", v, 32'd0);
    rd(2'd2, v); chk("reset_data", v, 32'h0000BAAD);
    rd(2'd3, v); chk("reset_cnt", v, 32'd0);

    // DATI from 001000 (octal) holding 123456 (octal)
    start_cycle(2'b00, 18'o001000);
`ifndef LILMASTER_NPR_EN
    k = 0;
    for (int i = 1; i <= int'(DSK) + 10; i++) begin
      @(negedge CLOCK);
      if (msyn_out_h) begin
        k = i;
        break;
      end
    end
    chk("msyn_delay", 32'(k), 32'(DSK + 1));
    chk("dati_addr", {14'd0, a_out_h}, {14'd0, 18'o001000});
    chk("dati_bbsy", {31'd0, bbsy_out_h}, 32'd1);
`endif
    finish_cycle(2'b00, 18'o001000);
    rd(2'd2, v); chk("dati_value", v, 32'h0000A72E);

    // DATO 0x1234 to 002000 (octal); data lines must hold through MSYN drop
    wr(2'd2, 32'h00001234);
    m_data = 16'h1234;
    start_cycle(2'b10, 18'o002000);
    bad = 1'b0; seen = 1'b0;
    for (int i = 0; i < int'(DSK) + 200; i++) begin
      @(negedge CLOCK);
      if (bbsy_out_h && d_out_h !== 16'h1234) bad = 1'b1;
      if (msyn_out_h) seen = 1'b1;
      if (seen && !msyn_out_h) break;
    end
    chk("dato_stable", {30'd0, seen, bad}, 32'd2);
    finish_cycle(2'b10, 18'o002000);
    chk("dato_mem", {16'd0, mem[12'h200]}, 32'h00001234);

    // DATOB 0x5600 at odd address 002001 (octal): only the high byte changes
    wr(2'd2, 32'h00005600);
    m_data = 16'h5600;
    start_cycle(2'b11, 18'o002001);
    wait_msyn(3 * DSK + 200);
    chk("datob_c", {30'd0, c_out_h}, 32'd3);
    finish_cycle(2'b11, 18'o002001);
    chk("datob_mem", {16'd0, mem[12'h200]}, 32'h00005634);

    // No responder: timeout after TMO cycles of MSYN
    resp_en = 1'b0;
    start_cycle(2'b00, 18'o000100);
    wait_msyn(3 * DSK + 200);
    hi = 0;
    for (int i = 0; i < int'(TMO) + 20; i++) begin
      if (!msyn_out_h) break;
      hi++;
      @(negedge CLOCK);
    end
    chk("msyn_high_cycles", 32'(hi), 32'(TMO));
    wait_idle(20);
    bus_idle_chk("timeout_bus");
    rd(2'd1, v); chk("timeout_csr", v, {2'b01, 10'd0, 2'b00, 18'o000100});
    rd(2'd2, v); chk("timeout_data", v, {16'd0, m_data});
    rd(2'd3, v); chk("timeout_cnt", v, {16'd0, m_cnt});

    // ARM abort while MSYN is up
    start_cycle(2'b10, 18'o000200);
    wait_msyn(3 * DSK + 200);
    wr(2'd3, 32'h80000000);
    wait_idle(10);
    bus_idle_chk("abort_bus");
    rd(2'd1, v); chk("abort_csr", v, {2'b01, 10'd0, 2'b10, 18'o000200});
    rd(2'd3, v); chk("abort_cnt", v, {16'd0, m_cnt});

    // INIT during MSYN; data register write while busy is dropped
    start_cycle(2'b00, 18'o000300);
    wait_msyn(3 * DSK + 200);
    wr(2'd2, 32'h00007777);
    rd(2'd2, v); chk("busy_wr_data", v, {16'd0, m_data});
    init_in_h = 1'b1;
    @(negedge CLOCK);
    bus_idle_chk("init_bus");
    rd(2'd1, v); chk("init_csr", v, {2'b01, 10'd0, 2'b00, 18'o000300});
    init_in_h = 1'b0;
    rd(2'd3, v); chk("init_cnt", v, {16'd0, m_cnt});
    resp_en = 1'b1;

`ifdef LILMASTER_NPR_EN
    // Grant delayed 20 cycles, foreign BBSY held 5 cycles past the grant
    gnt_dly = 20;
    bbsy_in_h = 1'b1;
    start_cycle(2'b00, 18'o001000);
    begin
      logic prev_npr;
      int   hold;
      int   rel_i;
      prev_npr = 1'b1; seen = 1'b0; hold = 0; rel_i = -1; bad = 1'b1;
      for (int i = 0; i < 300; i++) begin
        @(negedge CLOCK);
        if (sack_out_h && !seen) begin
          seen = 1'b1;
          chk("npr_drop", {30'd0, prev_npr, npr_out_h}, 32'd2);
        end
        prev_npr = npr_out_h;
        if (seen && bbsy_in_h) begin
          hold++;
          if (hold == 5) begin
            bbsy_in_h = 1'b0;
            rel_i = i;
          end
        end
        if (bbsy_out_h) begin
          bad = (rel_i < 0) || (i <= rel_i) || bbsy_in_h;
          break;
        end
      end
      chk("npr_bbsy_order", {30'd0, seen, bad}, 32'd2);
    end
    gnt_dly = 2;
    finish_cycle(2'b00, 18'o001000);
`else
    start_cycle(2'b10, 18'o000400);
    bad = 1'b0;
    for (int i = 0; i < int'(DSK) + 10; i++) begin
      @(negedge CLOCK);
      if (npr_out_h || sack_out_h) bad = 1'b1;
    end
    chk("arb_tied_off", {31'd0, bad}, 32'd0);
    finish_cycle(2'b10, 18'o000400);
`endif

    // Random transfers with random responder latency
    for (int n = 0; n < 24; n++) begin
      f = 2'($urandom_range(0, 3));
      a = {5'd0, 13'($urandom)};
      d = 16'($urandom);
      resp_lat = int'($urandom_range(0, 4));
      wr(2'd2, {16'd0, d});
      m_data = d;
      start_cycle(f, a);
      finish_cycle(f, a);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
